// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: opcodes, FSM encoding and flag indices.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f = 4'b0000;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next-state for one shift-add step; done flags the cycle after the last step.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = op_a;
      mplier_d = op_b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      done_d   = (cnt_q == CW'(1));
    end else begin
      done_d = 1'b0;
    end
  end

  // Multiplier state register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign busy    = (cnt_q != '0);
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and flags; MUL runs iteratively in a sub-module.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int MUL_ENABLE = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] busw_q, busw_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic             mul_fin;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   shamt;
  logic [3:0]       res_flags;
  logic [3:0]       mul_flags;

  assign add_w  = {1'b0, BusA} + {1'b0, BusB};
  assign sub_w  = {1'b0, BusA} + {1'b0, ~BusB} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt  = BusB[SHW-1:0];
  assign is_mul = (ALUCtrl == OP_MUL) && (MUL_ENABLE != 0);

  // Combinational op mux; MUL and undefined codes produce 0 here.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUCtrl)
      OP_AND:   alu_res = BusA & BusB;
      OP_OR:    alu_res = BusA | BusB;
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (add_w[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_LSL:   alu_res = BusA << shamt;
      OP_LSR:   alu_res = BusA >> shamt;
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (sub_w[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_PASSB: alu_res = BusB;
      default:  alu_res = '0;
    endcase
  end

  assign res_flags = pack_flags(alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v);
  assign mul_flags = pack_flags(mul_product == '0, mul_product[WIDTH-1], 1'b0, 1'b0);

  // Input readiness per state; in HOLD it follows the consumer directly.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_MUL:  in_ready = 1'b0;
      ST_HOLD: in_ready = OutReady;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept  = InValid && in_ready;
  assign mul_fin = (cnt_q == '0) && mul_done && !mul_busy;

  // FSM next-state; an accept in IDLE or HOLD overrides the per-state default.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busw_d      = busw_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
      ST_MUL: begin
        if (mul_fin) begin
          state_d     = ST_HOLD;
          busw_d      = mul_product;
          flags_d     = mul_flags;
          out_valid_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_HOLD: begin
        if (OutReady) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d     = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    if (accept) begin
      if (is_mul) begin
        state_d     = ST_MUL;
        cnt_d       = CW'(WIDTH);
        out_valid_d = 1'b0;
        mul_start   = 1'b1;
      end else begin
        state_d     = ST_HOLD;
        busw_d      = alu_res;
        flags_d     = res_flags;
        out_valid_d = 1'b1;
      end
    end else begin
      mul_start = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busw_q      <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busw_q      <= busw_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  if (MUL_ENABLE != 0) begin : g_mul
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .CLK     (CLK),
      .Reset   (Reset),
      .start   (mul_start),
      .op_a    (BusA),
      .op_b    (BusB),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
    );
  end else begin : g_no_mul
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
  end

  assign InReady  = in_ready;
  assign OutValid = out_valid_q;
  assign BusW     = busw_q;
  assign Zero     = flags_q[FLAG_Z];
  assign Negative = flags_q[FLAG_N];
  assign Carry    = flags_q[FLAG_C];
  assign Overflow = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a 64-bit and an 8-bit instance, directed cases plus randomized traffic
// scored against an arithmetic reference model with an in-order expected-result FIFO.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [63:0] res;
    logic z, n, c, v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, in_valid, out_ready;
  logic [1:0]  in_ready, out_valid, zf, nf, cf, vf;
  logic [3:0]  ctrl [2];
  logic [63:0] bus_a [2];
  logic [63:0] bus_b [2];
  logic [63:0] busw0;
  logic [7:0]  busw1;
  logic [63:0] busw [2];

  assign busw[0] = busw0;
  assign busw[1] = {56'h0, busw1};

  alu_pipe #(.WIDTH(64), .MUL_ENABLE(1)) u_dut64 (
    .CLK(clk), .Reset(rst[0]), .InValid(in_valid[0]), .InReady(in_ready[0]),
    .ALUCtrl(ctrl[0]), .BusA(bus_a[0]), .BusB(bus_b[0]),
    .OutValid(out_valid[0]), .OutReady(out_ready[0]), .BusW(busw0),
    .Zero(zf[0]), .Negative(nf[0]), .Carry(cf[0]), .Overflow(vf[0]));

  alu_pipe #(.WIDTH(8), .MUL_ENABLE(1)) u_dut8 (
    .CLK(clk), .Reset(rst[1]), .InValid(in_valid[1]), .InReady(in_ready[1]),
    .ALUCtrl(ctrl[1]), .BusA(bus_a[1][7:0]), .BusB(bus_b[1][7:0]),
    .OutValid(out_valid[1]), .OutReady(out_ready[1]), .BusW(busw1),
    .Zero(zf[1]), .Negative(nf[1]), .Carry(cf[1]), .Overflow(vf[1]));

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t fifo [2][8];
  int   wp [2] = '{0, 0};
  int   rp [2] = '{0, 0};
  logic held [2] = '{1'b0, 1'b0};
  exp_t snap [2];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", nm, got, exp);
    end
  endtask

  // Reference: what the ALU must return for op/a/b at datapath width w.
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a_in,
                                 input logic [63:0] b_in, input int w);
    exp_t e;
    logic [63:0] mask, a, b;
    logic [64:0] wide;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    e = '0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        wide  = {1'b0, a} + {1'b0, b};
        e.res = wide[63:0] & mask;
        e.c   = wide[w];
        e.v   = (a[w-1] == b[w-1]) && (e.res[w-1] != a[w-1]);
      end
      4'b0011: e.res = (a << (b % 64'(w))) & mask;
      4'b0100: e.res = a >> (b % 64'(w));
      4'b0110: begin
        e.res = (a - b) & mask;
        e.c   = (a >= b);
        e.v   = (a[w-1] != b[w-1]) && (e.res[w-1] != a[w-1]);
      end
      4'b0111: e.res = b;
      4'b1000: e.res = (a * b) & mask;
      default: e.res = 64'd0;
    endcase
    e.z = (e.res == 64'd0);
    e.n = e.res[w-1];
    return e;
  endfunction

  // Checks every negedge: in-order results, backpressure stability and readiness.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst[d]) begin
          rp[d]   = wp[d];
          held[d] = 1'b0;
        end else begin
          if (held[d]) begin
            chk1("hold_valid", out_valid[d], 1'b1);
            chk("hold_busw", busw[d], snap[d].res);
            chk("hold_flags", {60'd0, zf[d], nf[d], cf[d], vf[d]},
                {60'd0, snap[d].z, snap[d].n, snap[d].c, snap[d].v});
          end
          if (out_valid[d] && !out_ready[d]) chk1("bp_inready", in_ready[d], 1'b0);
          if (!out_valid[d]) chk1("inready_pending", in_ready[d], rp[d] == wp[d]);
          if (out_valid[d]) chk1("valid_has_pending", rp[d] != wp[d], 1'b1);
          if (out_valid[d] && out_ready[d] && (rp[d] != wp[d])) begin
            e = fifo[d][rp[d] % 8];
            rp[d]++;
            chk("result", busw[d], e.res);
            chk("flags", {60'd0, zf[d], nf[d], cf[d], vf[d]}, {60'd0, e.z, e.n, e.c, e.v});
            held[d] = 1'b0;
          end else if (out_valid[d] && !out_ready[d]) begin
            snap[d] = '{res: busw[d], z: zf[d], n: nf[d], c: cf[d], v: vf[d]};
            held[d] = 1'b1;
          end else begin
            held[d] = 1'b0;
          end
          if (in_valid[d] && in_ready[d]) begin
            fifo[d][wp[d] % 8] = model(ctrl[d], bus_a[d], bus_b[d], (d == 0) ? 64 : 8);
            wp[d]++;
          end
        end
      end
    end
  endtask

  task automatic drive(input int d, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b);
    in_valid[d] = 1'b1;
    ctrl[d]     = op;
    bus_a[d]    = a;
    bus_b[d]    = b;
  endtask

  // Holds InValid until accepted; returns just after the accepting edge.
  task automatic wait_accept(input int d, input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready[d]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_accept: not accepted in 200 cycles, expected acceptance", nm);
    end
  endtask

  function automatic logic [3:0] pick_op(input int d);
    logic [3:0] tbl [8];
    logic [3:0] op;
    tbl = '{OP_AND, OP_OR, OP_ADD, OP_LSL, OP_LSR, OP_SUB, OP_PASSB, OP_MUL};
    if ($urandom_range(0, 9) == 0) begin
      op = 4'($urandom_range(0, 15));
    end else begin
      op = tbl[$urandom_range(0, 7)];
    end
    if (op == OP_MUL && d == 0 && $urandom_range(0, 2) != 0) op = OP_SUB;
    return op;
  endfunction

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 9))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(0, 130));
      5:       return {56'd0, 8'($urandom_range(126, 129))};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_rand(input int d, input int nops);
    int acc;
    int cyc;
    bit took;
    bit drained;
    acc = 0;
    cyc = 0;
    while (acc < nops && cyc < 30000) begin
      @(negedge clk);
      took = in_valid[d] && in_ready[d];
      @(posedge clk);
      #1;
      cyc++;
      if (took) acc++;
      out_ready[d] = ($urandom_range(0, 3) != 0);
      if (took || !in_valid[d] || ($urandom_range(0, 7) == 0)) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid[d] = 1'b0;
        end else begin
          drive(d, pick_op(d), pick_val(), pick_val());
        end
      end
    end
    chk1("rand_progress", acc >= nops, 1'b1);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 200 && !drained; k++) begin
      @(negedge clk);
      if (rp[d] == wp[d] && !out_valid[d]) drained = 1'b1;
    end
    chk1("rand_drained", drained, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 2'b11;
    in_valid  = 2'b00;
    out_ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      ctrl[d]  = 4'b0000;
      bus_a[d] = 64'd0;
      bus_b[d] = 64'd0;
    end
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst = 2'b00;

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk1("rst_outvalid", out_valid[d], 1'b0);
      chk("rst_busw", busw[d], 64'd0);
      chk("rst_flags", {60'd0, zf[d], nf[d], cf[d], vf[d]}, 64'd0);
      chk1("rst_inready", in_ready[d], 1'b1);
    end

    @(posedge clk); #1;
    drive(0, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_accept(0, "add");
    @(negedge clk);
    chk1("add_valid", out_valid[0], 1'b1);
    chk("add_busw", busw[0], 64'd0);
    chk1("add_zero", zf[0], 1'b1);
    chk1("add_carry", cf[0], 1'b1);
    chk1("add_ovf", vf[0], 1'b0);

    @(posedge clk); #1;
    drive(0, OP_SUB, 64'h8000_0000_0000_0000, 64'd1);
    wait_accept(0, "sub");
    @(negedge clk);
    chk("sub_busw", busw[0], 64'h7FFF_FFFF_FFFF_FFFF);
    chk1("sub_carry", cf[0], 1'b1);
    chk1("sub_ovf", vf[0], 1'b1);
    chk1("sub_neg", nf[0], 1'b0);

    @(posedge clk); #1;
    drive(0, OP_LSL, 64'd1, 64'd65);
    wait_accept(0, "lsl");
    @(negedge clk);
    chk("lsl_busw", busw[0], 64'd2);

    @(posedge clk); #1;
    drive(0, OP_LSR, 64'h8000_0000_0000_0000, 64'd63);
    wait_accept(0, "lsr");
    @(negedge clk);
    chk("lsr_busw", busw[0], 64'd1);

    // Backpressure: AND held while an OR waits, OR taken on the edge OutReady returns.
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    drive(0, OP_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    wait_accept(0, "bp_and");
    drive(0, OP_OR, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_busw", busw[0], 64'hF000_F000_F000_F000);
      chk1("bp_inready0", in_ready[0], 1'b0);
      chk1("bp_valid", out_valid[0], 1'b1);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk1("bp_inready1", in_ready[0], 1'b1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_or_busw", busw[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk1("bp_or_valid", out_valid[0], 1'b1);

    // Reset in the middle of a 64-bit multiply.
    @(posedge clk); #1;
    drive(0, OP_MUL, 64'd3, 64'd5);
    wait_accept(0, "mul64");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("mul64_inready", in_ready[0], 1'b0);
      @(posedge clk);
    end
    #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk1("mrst_valid", out_valid[0], 1'b0);
    chk("mrst_busw", busw[0], 64'd0);
    chk("mrst_flags", {60'd0, zf[0], nf[0], cf[0], vf[0]}, 64'd0);
    chk1("mrst_inready", in_ready[0], 1'b1);
    @(posedge clk); #1;
    drive(0, OP_PASSB, 64'd123, 64'hDEAD);
    wait_accept(0, "passb");
    @(negedge clk);
    chk("passb_busw", busw[0], 64'hDEAD);

    // 8-bit multiply: result exactly WIDTH+1 cycles after the accepting edge.
    @(posedge clk); #1;
    drive(1, OP_MUL, 64'd13, 64'd11);
    wait_accept(1, "mul8");
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk1("mul8_not_valid", out_valid[1], 1'b0);
      chk1("mul8_inready", in_ready[1], 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    chk1("mul8_valid", out_valid[1], 1'b1);
    chk("mul8_busw", busw[1], 64'h8F);
    @(posedge clk); #1;

    run_rand(0, 200);
    run_rand(1, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
